// File: rtl/line_clearer_pkg.sv
// Shared playfield geometry, cell/row/field types, scoring constants and FSM
// encoding for the line clearer.
package line_clearer_pkg;

  localparam int FIELD_W = 10;
  localparam int FIELD_H = 20;
  localparam int CELL_W  = 3;
  localparam int LINES_W = 5;
  localparam int SCORE_W = 11;

  typedef logic [CELL_W-1:0]  cell_t;
  typedef cell_t [FIELD_W-1:0] row_t;
  typedef row_t [FIELD_H-1:0]  field_t;

  localparam logic [LINES_W-1:0] LAST_ROW = 5'd19;

  localparam logic [SCORE_W-1:0] SCORE_SINGLE = 11'd40;
  localparam logic [SCORE_W-1:0] SCORE_DOUBLE = 11'd100;
  localparam logic [SCORE_W-1:0] SCORE_TRIPLE = 11'd300;
  localparam logic [SCORE_W-1:0] SCORE_TETRIS = 11'd1200;

  typedef struct packed {
    field_t               field;
    logic [SCORE_W-1:0]   score;
    logic [LINES_W-1:0]   lines;
  } game_data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [SCORE_W-1:0] score_lookup(input logic [LINES_W-1:0] lines);
    logic [SCORE_W-1:0] score;
    case (lines)
      5'd0:    score = 11'd0;
      5'd1:    score = SCORE_SINGLE;
      5'd2:    score = SCORE_DOUBLE;
      5'd3:    score = SCORE_TRIPLE;
      default: score = SCORE_TETRIS;
    endcase
    return score;
  endfunction

endpackage

// File: rtl/line_clearer_if.sv
// Start/field request and cleaned-field result bundle between the game core
// (master) and the line clearer (slave).
interface line_clearer_if;
  import line_clearer_pkg::*;

  logic                 start_i;
  field_t               field_i;
  field_t               field_o;
  logic                 busy_o;
  logic                 done_o;
  logic [LINES_W-1:0]   lines_o;
  logic [SCORE_W-1:0]   score_add_o;

  modport slave (
    input  start_i, field_i,
    output field_o, busy_o, done_o, lines_o, score_add_o
  );

  modport master (
    output start_i, field_i,
    input  field_o, busy_o, done_o, lines_o, score_add_o
  );
endinterface

// File: rtl/line_clearer_row_is_full.sv
// Combinational full-row detector: high when every cell of the row holds a
// non-zero colour.
module row_is_full
  import line_clearer_pkg::*;
(
  input  row_t row_i,
  output logic full_o
);

  // AND together the per-cell occupancy bits
  always_comb begin
    full_o = 1'b1;
    for (int c = 0; c < FIELD_W; c++) begin
      full_o = full_o & (|row_i[c]);
    end
  end

endmodule

// File: rtl/line_clearer.sv
// Scans a locked playfield bottom-up one row per cycle, collapses every full
// row by shifting the rows above it down, and reports lines cleared and score.
module line_clearer
  import line_clearer_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n_i,
  line_clearer_if.slave bus
);

  state_t               state_q, state_d;
  field_t               work_q, work_d;
  logic [LINES_W-1:0]   r_q, r_d;
  logic [LINES_W-1:0]   k_q, k_d;
  logic [LINES_W-1:0]   cnt_q, cnt_d;
  field_t               field_q, field_d;
  logic [LINES_W-1:0]   lines_q, lines_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  row_t                 cur_row_s;
  logic                 row_full_s;

  assign cur_row_s = work_q[r_q];

  row_is_full u_row_is_full (
    .row_i  (cur_row_s),
    .full_o (row_full_s)
  );

  // Next-state, working-array update and result capture
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    r_d     = r_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    field_d = field_q;
    lines_d = lines_q;
    score_d = score_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          work_d  = bus.field_i;
          r_d     = LAST_ROW;
          cnt_d   = 5'd0;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        // The detecting cycle already performs the first row move, so a
        // full row at position r costs r+1 cycles in total.
        if (row_full_s) begin
          if (r_q == 5'd0) begin
            work_d[0] = '0;
            cnt_d     = cnt_q + 5'd1;
          end else begin
            work_d[r_q] = work_q[r_q - 5'd1];
            k_d         = r_q - 5'd1;
            state_d     = ST_SHIFT;
          end
        end else if (r_q != 5'd0) begin
          r_d = r_q - 5'd1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (k_q == 5'd0) begin
          work_d[0] = '0;
          cnt_d     = cnt_q + 5'd1;
          state_d   = ST_CHECK;
        end else begin
          work_d[k_q] = work_q[k_q - 5'd1];
          k_d         = k_q - 5'd1;
        end
      end
      ST_DONE: begin
        field_d = work_q;
        lines_d = cnt_q;
        score_d = score_lookup(cnt_q);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_CHECK) || (state_d == ST_SHIFT);
  end

  // State, working array and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      r_q     <= 5'd0;
      k_q     <= 5'd0;
      cnt_q   <= 5'd0;
      field_q <= '0;
      lines_q <= 5'd0;
      score_q <= 11'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      r_q     <= r_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      field_q <= field_d;
      lines_q <= lines_d;
      score_q <= score_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.field_o     = field_q;
  assign bus.lines_o     = lines_q;
  assign bus.score_add_o = score_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_line_clearer.sv
// Self-checking bench for line_clearer: directed scenarios plus random fields
// checked against a row-compaction reference model.
module tb_line_clearer;
  import line_clearer_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  line_clearer_if bus();

  line_clearer dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: drop full rows, pack survivors to the bottom in order, and
  // charge each removed row its current position + 1 cycles.
  function automatic void model(input field_t f, output field_t o, output int n, output int lat);
    int  w;
    logic full;
    o   = '0;
    n   = 0;
    lat = 21;
    w   = FIELD_H - 1;
    for (int r = FIELD_H - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < FIELD_W; c++) if (f[r][c] == 3'd0) full = 1'b0;
      if (full) begin
        lat += r + n + 1;
        n++;
      end else begin
        o[w] = f[r];
        w--;
      end
    end
  endfunction

  function automatic int exp_score(input int n);
    if (n == 0) return 0;
    if (n == 1) return 40;
    if (n == 2) return 100;
    if (n == 3) return 300;
    return 1200;
  endfunction

  function automatic row_t full_row();
    row_t rw;
    for (int c = 0; c < FIELD_W; c++) rw[c] = cell_t'($urandom_range(1, 7));
    return rw;
  endfunction

  function automatic row_t partial_row();
    row_t rw;
    for (int c = 0; c < FIELD_W; c++) rw[c] = cell_t'($urandom_range(0, 7));
    rw[$urandom_range(0, FIELD_W - 1)] = 3'd0;
    return rw;
  endfunction

  // Pulse start, optionally pulse it again at cycle pulse_at, wait for done_o
  task automatic run_op(input field_t f, input int pulse_at, output int lat,
                        output logic busy1, output logic busy_done, output int extra_done);
    @(negedge clk);
    bus.field_i = f;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    lat   = 0;
    busy1 = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) busy1 = bus.busy_o;
      bus.start_i = (lat == pulse_at);
    end while (!bus.done_o && lat < 1000);
    busy_done   = bus.busy_o;
    bus.start_i = 1'b0;
    extra_done  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done_o) extra_done++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_flags got done=%b busy=%b exp 0/0", bus.done_o, bus.busy_o); end
    total++; if (bus.lines_o !== 5'd0 || bus.score_add_o !== 11'd0) begin bad++; $display("FAIL reset_counts got lines=%0d score=%0d exp 0/0", bus.lines_o, bus.score_add_o); end
    total++; if (bus.field_o !== field_t'(0)) begin bad++; $display("FAIL reset_field got %h exp 0", bus.field_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    int lat, extra; logic b1, bd;
    run_op(field_t'(0), 0, lat, b1, bd, extra);
    total++; if (lat !== 21) begin bad++; $display("FAIL empty_latency got %0d exp 21", lat); end
    total++; if (bus.lines_o !== 5'd0 || bus.score_add_o !== 11'd0) begin bad++; $display("FAIL empty_counts got lines=%0d score=%0d exp 0/0", bus.lines_o, bus.score_add_o); end
    total++; if (bus.field_o !== field_t'(0)) begin bad++; $display("FAIL empty_field got %h exp 0", bus.field_o); end
    total++; if (b1 !== 1'b1 || bd !== 1'b0) begin bad++; $display("FAIL empty_busy got first=%b at_done=%b exp 1/0", b1, bd); end
    total++; if (extra !== 0) begin bad++; $display("FAIL empty_done_pulse got %0d extra pulses exp 0", extra); end
  endtask

  task automatic test_single(input int pulse_at, input string tag);
    field_t f, e; int lat, extra; logic b1, bd;
    f = '0; f[19] = full_row(); f[18][0] = 3'd3;
    e = '0; e[19][0] = 3'd3;
    run_op(f, pulse_at, lat, b1, bd, extra);
    total++; if (lat !== 41) begin bad++; $display("FAIL %s_latency got %0d exp 41", tag, lat); end
    total++; if (bus.lines_o !== 5'd1 || bus.score_add_o !== 11'd40) begin bad++; $display("FAIL %s_counts got lines=%0d score=%0d exp 1/40", tag, bus.lines_o, bus.score_add_o); end
    total++; if (bus.field_o !== e) begin bad++; $display("FAIL %s_field got %h exp %h", tag, bus.field_o, e); end
    total++; if (extra !== 0) begin bad++; $display("FAIL %s_done_pulse got %0d extra pulses exp 0", tag, extra); end
  endtask

  task automatic test_four();
    field_t f, e; row_t p; int lat, extra; logic b1, bd;
    f = '0;
    for (int r = 16; r < 20; r++) f[r] = full_row();
    p = partial_row(); f[15] = p;
    e = '0; e[19] = p;
    run_op(f, 0, lat, b1, bd, extra);
    total++; if (lat !== 101) begin bad++; $display("FAIL four_latency got %0d exp 101", lat); end
    total++; if (bus.lines_o !== 5'd4 || bus.score_add_o !== 11'd1200) begin bad++; $display("FAIL four_counts got lines=%0d score=%0d exp 4/1200", bus.lines_o, bus.score_add_o); end
    total++; if (bus.field_o !== e) begin bad++; $display("FAIL four_field got %h exp %h", bus.field_o, e); end
  endtask

  task automatic test_gap();
    field_t f, e; row_t p; int lat, extra; logic b1, bd;
    f = '0; f[19] = full_row(); f[17] = full_row();
    p = partial_row(); f[18] = p;
    e = '0; e[19] = p;
    run_op(f, 0, lat, b1, bd, extra);
    total++; if (lat !== 60) begin bad++; $display("FAIL gap_latency got %0d exp 60", lat); end
    total++; if (bus.lines_o !== 5'd2 || bus.score_add_o !== 11'd100) begin bad++; $display("FAIL gap_counts got lines=%0d score=%0d exp 2/100", bus.lines_o, bus.score_add_o); end
    total++; if (bus.field_o !== e) begin bad++; $display("FAIL gap_field got %h exp %h", bus.field_o, e); end
  endtask

  task automatic test_all_full();
    field_t f; int lat, extra; logic b1, bd;
    for (int r = 0; r < FIELD_H; r++) f[r] = full_row();
    run_op(f, 0, lat, b1, bd, extra);
    total++; if (lat !== 421) begin bad++; $display("FAIL allfull_latency got %0d exp 421", lat); end
    total++; if (bus.lines_o !== 5'd20 || bus.score_add_o !== 11'd1200) begin bad++; $display("FAIL allfull_counts got lines=%0d score=%0d exp 20/1200", bus.lines_o, bus.score_add_o); end
    total++; if (bus.field_o !== field_t'(0)) begin bad++; $display("FAIL allfull_field got %h exp 0", bus.field_o); end
  endtask

  task automatic test_reset_mid();
    field_t f; int lat, extra, dones; logic b1, bd;
    f = '0; f[19] = full_row(); f[10] = partial_row();
    @(negedge clk);
    bus.field_i = f; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin bad++; $display("FAIL midrst_flags got busy=%b done=%b exp 0/0", bus.busy_o, bus.done_o); end
    total++; if (bus.field_o !== field_t'(0) || bus.lines_o !== 5'd0 || bus.score_add_o !== 11'd0) begin bad++; $display("FAIL midrst_outputs got lines=%0d score=%0d field=%h exp zeros", bus.lines_o, bus.score_add_o, bus.field_o); end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_no_done got %0d pulses exp 0", dones); end
    run_op(f, 0, lat, b1, bd, extra);
    total++; if (lat !== 41 || bus.lines_o !== 5'd1) begin bad++; $display("FAIL midrst_rerun got lat=%0d lines=%0d exp 41/1", lat, bus.lines_o); end
  endtask

  task automatic test_random();
    field_t f, e; int n, elat, lat, extra; logic b1, bd;
    for (int it = 0; it < 8; it++) begin
      for (int r = 0; r < FIELD_H; r++) begin
        case ($urandom_range(0, 3))
          0:       f[r] = '0;
          1:       f[r] = full_row();
          default: f[r] = partial_row();
        endcase
      end
      model(f, e, n, elat);
      run_op(f, 0, lat, b1, bd, extra);
      total++; if (lat !== elat) begin bad++; $display("FAIL rand%0d_latency got %0d exp %0d", it, lat, elat); end
      total++; if (int'(bus.lines_o) !== n || int'(bus.score_add_o) !== exp_score(n)) begin bad++; $display("FAIL rand%0d_counts got lines=%0d score=%0d exp %0d/%0d", it, bus.lines_o, bus.score_add_o, n, exp_score(n)); end
      total++; if (bus.field_o !== e) begin bad++; $display("FAIL rand%0d_field got %h exp %h", it, bus.field_o, e); end
    end
  endtask

  task automatic test_hold();
    field_t f, e; int n, elat, lat, extra; logic b1, bd;
    f = '0; f[19] = full_row(); f[18] = full_row(); f[17] = full_row(); f[5] = partial_row();
    model(f, e, n, elat);
    run_op(f, 0, lat, b1, bd, extra);
    bus.field_i = '1;
    repeat (20) @(negedge clk);
    total++; if (bus.field_o !== e || int'(bus.lines_o) !== n || bus.score_add_o !== 11'd300) begin bad++; $display("FAIL hold got lines=%0d score=%0d field=%h exp %0d/300 %h", bus.lines_o, bus.score_add_o, bus.field_o, n, e); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.start_i = 1'b0;
    bus.field_i = '0;
    test_reset();
    test_empty();
    test_single(0, "single");
    test_single(5, "restart");
    test_four();
    test_gap();
    test_reset_mid();
    test_all_full();
    test_random();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_clearer.md
LINE_CLEARER -- requirements
Module: line_clearer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_i  input  1  system clock; every register updates on its rising edge.
REQ-003 rst_n_i  input  1  asynchronous active-low reset.
REQ-004 start_i  input  1  single-cycle pulse: a piece has locked, so scan field_i.
REQ-005 field_i  input  FIELD_H*FIELD_W*CELL_W  playfield snapshot with the locked piece merged in; row 0 is the top row, cell 0 is the leftmost.
REQ-006 field_o  output  FIELD_H*FIELD_W*CELL_W  cleaned playfield, fed to the game_data_t field member.
REQ-007 busy_o  output  1  high while a scan or shift is in progress.
REQ-008 done_o  output  1  single-cycle pulse when field_o, lines_o and score_add_o become valid.
REQ-009 lines_o  output  5  number of rows removed by the last operation (0..20).
REQ-010 score_add_o  output  11  score increment for the last operation.

Function
REQ-011 A cell value of 0 SHALL mean empty; values 1..7 SHALL mean occupied, and the value is the colour index.
REQ-012 A row SHALL be full when all FIELD_W cells are non-zero.
REQ-013 FSM states SHALL be IDLE, CHECK, SHIFT and DONE.
REQ-014 IDLE: start_i=1 SHALL copy field_i into a working array, set row pointer r=FIELD_H-1, clear the line counter and go to CHECK.
REQ-015 CHECK: the FSM SHALL test one row (row r) per cycle.
  - Row r full: go to SHIFT with shift pointer k=r.
  - Row r not full and r>0: decrement r and stay in CHECK.
  - Row r not full and r=0: go to DONE.
REQ-016 SHIFT: each cycle SHALL write working row k from working row k-1 and decrement k.
  - At k=0, row 0 SHALL be written all-zero, the line counter SHALL increment, and the FSM SHALL return to CHECK with r unchanged, so the same row is re-tested.
  - SHIFT for row r SHALL therefore take r+1 cycles.
REQ-017 DONE (one cycle): the block SHALL register the working array to field_o, the counter to lines_o and the lookup to score_add_o, assert done_o, then return to IDLE.
REQ-018 score_add_o SHALL use lines 0/1/2/3/≥4 -> 0/40/100/300/1200.
REQ-019 With no full rows, done_o SHALL assert exactly 21 cycles after the edge that sampled start_i.
REQ-020 Each full row at original index r SHALL add r+1 cycles to that latency, measured at its position when reached.
REQ-021 busy_o SHALL be high in CHECK and SHIFT, and low in IDLE and DONE.
REQ-022 start_i while busy_o=1 or in DONE SHALL be ignored; it SHALL neither queue nor restart.
REQ-023 field_o, lines_o and score_add_o SHALL hold their previous values between done_o pulses.
REQ-024 Non-adjacent full rows SHALL all be removed, because CHECK re-tests the shifted row.
REQ-025 An all-full field SHALL yield an all-zero field_o and lines_o=20.

Reset
REQ-026 While rst_n_i=0, the block SHALL be in IDLE with field_o=0, lines_o=0, score_add_o=0, busy_o=0, done_o=0, and the working array and pointers cleared.
REQ-027 Reset asserted mid-CHECK or mid-SHIFT SHALL abort the operation with no done_o pulse; the first start_i after release SHALL be honoured.

Structure
REQ-028 FIELD_W=10, FIELD_H=20, CELL_W=3, the field typedef and the score constants (40/100/300/1200) SHALL live in the shared package/defs.vh alongside game_data_t.
REQ-029 The full-row test SHALL be a combinational sub-module row_is_full (row in, full out), instantiated once on the row selected by r.

Verification
REQ-030 Empty field, start_i -> done_o exactly 21 cycles later; lines_o=0; score_add_o=0; field_o all zero.
REQ-031 Row 19 full, row 18 = cell0 colour 3 only -> lines_o=1, score_add_o=40, field_o row 19 = cell0 colour 3, done_o at cycle 41.
REQ-032 Rows 16..19 full, row 15 partially filled -> lines_o=4, score_add_o=1200, row 15 content moved to row 19, rows 0..18 empty.
REQ-033 Rows 19 and 17 full, row 18 pattern P -> lines_o=2, score_add_o=100, P in row 19.
REQ-034 start_i pulsed again at cycle 5 of an operation -> ignored; only one done_o pulse, with results equal to the single-start case.
REQ-035 rst_n_i low for 2 cycles mid-SHIFT -> outputs zero, no done_o; a new start_i then completes normally.
